uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- Receive-only RS-232 block: deserialises 8N1 frames from `serial_in` and pushes each good byte into an internal FIFO.
- The FIFO head is shown as two hex nibbles (`data_out_msd`, `data_out_lsd`) for seven-segment display logic.
- The user steps through received bytes with `display_next`.
- Flags report FIFO full, FIFO empty and receive errors.

Parameters:
- CLKS_PER_BIT, default 5208: CLK cycles per bit period (50 MHz / 9600 baud); must be >= 4.
- FIFO_DEPTH, default 16: number of byte entries; power of two.

Ports:
- CLK  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- serial_in  in  1  asynchronous UART line; idles high.
- display_next  in  1  level request to advance the display; rising edge acts.
- error  out  1  sticky error flag.
- fifo_full  out  1  FIFO holds FIFO_DEPTH bytes.
- fifo_empty  out  1  FIFO holds 0 bytes.
- data_out_msd  out  4  FIFO head byte [7:4].
- data_out_lsd  out  4  FIFO head byte [3:0].

Behaviour:
- One clock (CLK). Reset is synchronous and active-high (reset).
- Reset state:
  - FSM in IDLE; FIFO cleared.
  - Outputs: error=0, fifo_full=0, fifo_empty=1, data_out_msd=0, data_out_lsd=0.
  - Synchronizer flops and the display_next edge register are set to 1/0 respectively.
- Reset mid-frame aborts the frame; no push.
- serial_in passes through a 2-flop synchronizer before use. All timing below is relative to the synchronized signal.
- FSM states: IDLE, START, DATA, STOP, WAIT_IDLE.
- IDLE: on a synced low, clear the bit counter and go to START.
- START:
  - Count CLKS_PER_BIT/2 cycles, then re-sample.
  - Low -> DATA.
  - High -> IDLE (glitch rejection; a 1-cycle low pulse never produces a byte or an error).
- DATA:
  - Sample every CLKS_PER_BIT cycles, 8 bits, LSB first, shifted into a byte register.
  - After bit 7 -> STOP.
- STOP: after CLKS_PER_BIT cycles, sample the line.
  - High: push the byte (if not full), go to IDLE.
  - Low: framing error; byte discarded; set error; go to WAIT_IDLE.
- WAIT_IDLE: stay until synced line is high, then go to IDLE.
- Overflow: a good byte arriving while fifo_full=1 is dropped, sets error, and leaves FIFO contents unchanged.
- error is sticky until reset.
- Pop:
  - display_next is rising-edge detected internally (registered previous value), so one press gives one pop.
  - Pop while empty is ignored; no error.
- Push and pop in the same cycle:
  - Both occur and the count is unchanged.
  - If empty, the push happens and the pop is ignored.
  - If full, the pop happens and the push is accepted.
- Data outputs:
  - data_out_msd/lsd always show the current head byte, combinationally from FIFO storage at the read pointer.
  - Forced to 0 when fifo_empty=1.
  - The head is visible the cycle after its push completes.
- Pointers are log2(FIFO_DEPTH)+1 bits wide and wrap modulo 2*FIFO_DEPTH.
  - empty = pointers equal.
  - full = MSBs differ and low bits equal.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Frame is 8E1; a PARITY state between DATA and STOP samples the parity bit.
  - Even-parity mismatch sets error and discards the byte. The FSM still checks the stop bit before returning to IDLE or WAIT_IDLE.
- Undefined: 8N1 only; no PARITY state.

Decomposition:
- Package uart_rx_pkg:
  - FSM state enum (IDLE, START, DATA, STOP, WAIT_IDLE, PARITY).
  - Localparams for data width 8 and nibble width 4.
- Sub-module uart_rx_fifo:
  - Synchronous FIFO, parameter FIFO_DEPTH.
  - Ports: push/data_in, pop, head, full, empty.
  - Same reset as the parent.

Test Plan (CLKS_PER_BIT=16, FIFO_DEPTH=4):
- Reset held 1 cycle after 10 idle cycles -> error=0, fifo_empty=1, fifo_full=0, msd=lsd=0.
- Line high then 1-cycle low glitch, then high for 1000 cycles -> no push; fifo_empty=1, error=0.
- Send 0xA5 (8N1) -> after the stop sample, fifo_empty=0, msd=4'hA, lsd=4'h5, error=0.
- Send 0x3C, then 0x7E; pulse display_next for 5 cycles -> exactly one pop; display changes 3/C -> 7/E. Second pulse -> fifo_empty=1, display 0/0.
- Send 5 bytes 0x01..0x05 with no pops -> fifo_full=1 after the 4th; 5th dropped; error=1; head still 0x01.
- Frame 0x55 with stop bit forced low, then line high, then a valid 0x12 -> error=1, only 0x12 in FIFO. Reset clears error and FIFO.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared types and constants for the uart_rx receiver.
//   - uart_rx_state_e : receive FSM state encoding
//   - DATA_W / NIBBLE_W : byte and display-nibble widths
//   - even_parity_err() : parity check used when UART_RX_PARITY_EN is defined
package uart_rx_pkg;

  localparam int DATA_W   = 8;
  localparam int NIBBLE_W = 4;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4,
    PARITY    = 3'd5
  } uart_rx_state_e;

  // Returns 1 when data plus the received parity bit has an odd number of ones.
  function automatic logic even_parity_err(input logic [DATA_W-1:0] data,
                                           input logic              par_bit);
    return (^data) ^ par_bit;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: synchronous byte FIFO holding received characters.
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset (clears pointers)
//   push_i/data_i  write request and byte
//   pop_i          read request (ignored when empty)
//   head_o         byte at the read pointer, 0 when empty
//   full_o/empty_o occupancy flags
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module uart_rx_fifo
  import uart_rx_pkg::*;
#(
  parameter int FIFO_DEPTH = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              push_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] head_o,
  output logic              full_o,
  output logic              empty_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]     wptr_q, wptr_d;
  logic [PW-1:0]     rptr_q, rptr_d;
  logic              do_push;
  logic              do_pop;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) &&
                   (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

  // A simultaneous pop frees the slot, so a push into a full FIFO is taken.
  assign do_push = push_i && (!full_o || pop_i);
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (do_push) wptr_d = wptr_q + 1'b1;
    if (do_pop)  rptr_d = rptr_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage needs no reset: it is only visible through a valid read pointer.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= data_i;
  end

  assign head_o = empty_o ? '0 : mem_q[rptr_q[AW-1:0]];

endmodule

// File: rtl/uart_rx.sv
// uart_rx: receive-only UART (8N1, or 8E1 when UART_RX_PARITY_EN is defined)
// feeding a byte FIFO whose head is shown as two hex nibbles.
// Ports:
//   CLK           system clock, rising edge
//   reset         synchronous active-high reset
//   serial_in     asynchronous UART line, idles high
//   display_next  level input; each rising edge pops one byte
//   error         sticky: framing, overflow (or parity) error seen
//   fifo_full     FIFO holds FIFO_DEPTH bytes
//   fifo_empty    FIFO holds no bytes
//   data_out_msd  head byte [7:4] (0 when empty)
//   data_out_lsd  head byte [3:0] (0 when empty)
//   dbg_state_o   current receive FSM state
// Optional feature macro: UART_RX_PARITY_EN (adds an even-parity bit state).
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 5208,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                CLK,
  input  logic                reset,
  input  logic                serial_in,
  input  logic                display_next,
  output logic                error,
  output logic                fifo_full,
  output logic                fifo_empty,
  output logic [NIBBLE_W-1:0] data_out_msd,
  output logic [NIBBLE_W-1:0] data_out_lsd,
  output uart_rx_state_e      dbg_state_o
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  // Two-flop synchronizer, reset to the idle (high) line level.
  logic sync1_q, sync2_q;
  logic rx;

  always_ff @(posedge CLK) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= serial_in;
      sync2_q <= sync1_q;
    end
  end

  assign rx = sync2_q;

  // display_next rising-edge detect: one press pops exactly one byte.
  logic next_prev_q;
  logic pop_req;

  always_ff @(posedge CLK) begin
    if (reset) next_prev_q <= 1'b0;
    else       next_prev_q <= display_next;
  end

  assign pop_req = display_next && !next_prev_q;

  // Receive FSM state and datapath registers.
  uart_rx_state_e    state_q, state_d;
  logic [CW-1:0]     clk_cnt_q, clk_cnt_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              error_q, error_d;
  logic              push_req;
  logic              frame_err;
  logic              overflow;
  logic              par_set;
`ifdef UART_RX_PARITY_EN
  logic              par_err_q, par_err_d;
`endif

  logic [DATA_W-1:0] head;

  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    push_req  = 1'b0;
    frame_err = 1'b0;
    par_set   = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_err_d = par_err_q;
`endif
    case (state_q)
      IDLE: begin
        if (!rx) begin
          bit_cnt_d = '0;
          clk_cnt_d = '0;
`ifdef UART_RX_PARITY_EN
          par_err_d = 1'b0;
`endif
          state_d   = START;
        end
      end
      // Re-check the line mid start bit; a short low pulse returns to IDLE.
      START: begin
        if (clk_cnt_q == HALF_LAST) begin
          clk_cnt_d = '0;
          state_d   = rx ? IDLE : DATA;
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (clk_cnt_q == BIT_LAST) begin
          clk_cnt_d = '0;
          shift_d   = {rx, shift_q[DATA_W-1:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (clk_cnt_q == BIT_LAST) begin
          clk_cnt_d = '0;
          par_err_d = even_parity_err(shift_q, rx);
          par_set   = even_parity_err(shift_q, rx);
          state_d   = STOP;
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
`endif
      STOP: begin
        if (clk_cnt_q == BIT_LAST) begin
          clk_cnt_d = '0;
          if (rx) begin
`ifdef UART_RX_PARITY_EN
            push_req = !par_err_q;
`else
            push_req = 1'b1;
`endif
            state_d  = IDLE;
          end else begin
            frame_err = 1'b1;
            state_d   = WAIT_IDLE;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      WAIT_IDLE: begin
        if (rx) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A good byte is lost only when full and no pop frees a slot this cycle.
  assign overflow = push_req && fifo_full && !pop_req;

  always_comb begin
    error_d = error_q;
    if (frame_err || overflow || par_set) error_d = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q   <= IDLE;
      clk_cnt_q <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      error_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      error_q   <= error_d;
`ifdef UART_RX_PARITY_EN
      par_err_q <= par_err_d;
`endif
    end
  end

  uart_rx_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_i  (CLK),
    .rst_i  (reset),
    .push_i (push_req),
    .data_i (shift_q),
    .pop_i  (pop_req),
    .head_o (head),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

  assign error        = error_q;
  assign data_out_msd = head[DATA_W-1:NIBBLE_W];
  assign data_out_lsd = head[NIBBLE_W-1:0];
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;
  import uart_rx_pkg::*;

  localparam int CPB   = 16;
  localparam int DEPTH = 4;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           serial_in = 1'b1;
  logic           display_next = 1'b0;
  logic           error;
  logic           fifo_full;
  logic           fifo_empty;
  logic [3:0]     data_out_msd;
  logic [3:0]     data_out_lsd;
  uart_rx_state_e dbg_state;

  int tests = 0;
  int fails = 0;

  uart_rx #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .CLK         (clk),
    .reset       (reset),
    .serial_in   (serial_in),
    .display_next(display_next),
    .error       (error),
    .fifo_full   (fifo_full),
    .fifo_empty  (fifo_empty),
    .data_out_msd(data_out_msd),
    .data_out_lsd(data_out_lsd),
    .dbg_state_o (dbg_state)
  );

  // Clock and reset
  always #5 clk = ~clk;

  task automatic do_reset();
    @(posedge clk);
    reset = 1'b1;
    @(posedge clk);
    reset = 1'b0;
  endtask

  // Drivers
  task automatic drive_bit(input logic v);
    serial_in = v;
    repeat (CPB) @(posedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    @(posedge clk);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(^b);
`endif
    drive_bit(stop_bit);
    serial_in = 1'b1;
    repeat (4) @(posedge clk);
  endtask

  task automatic pulse_next(input int n);
    @(posedge clk);
    display_next = 1'b1;
    repeat (n) @(posedge clk);
    display_next = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  // Scenarios
  task automatic test_reset();
    serial_in = 1'b1;
    repeat (10) @(posedge clk);
    do_reset();
    @(negedge clk);
    tests++; if (error !== 1'b0) begin fails++; $display("FAIL reset_error got=%b exp=0", error); end
    tests++; if (fifo_empty !== 1'b1) begin fails++; $display("FAIL reset_empty got=%b exp=1", fifo_empty); end
    tests++; if (fifo_full !== 1'b0) begin fails++; $display("FAIL reset_full got=%b exp=0", fifo_full); end
    tests++; if ({data_out_msd, data_out_lsd} !== 8'h00) begin fails++; $display("FAIL reset_data got=%h exp=00", {data_out_msd, data_out_lsd}); end
    tests++; if (dbg_state !== IDLE) begin fails++; $display("FAIL reset_state got=%0d exp=%0d", dbg_state, IDLE); end
  endtask

  task automatic test_glitch();
    do_reset();
    @(posedge clk);
    serial_in = 1'b0;
    @(posedge clk);
    serial_in = 1'b1;
    repeat (1000) @(posedge clk);
    @(negedge clk);
    tests++; if (fifo_empty !== 1'b1) begin fails++; $display("FAIL glitch_empty got=%b exp=1", fifo_empty); end
    tests++; if (error !== 1'b0) begin fails++; $display("FAIL glitch_error got=%b exp=0", error); end
    tests++; if (dbg_state !== IDLE) begin fails++; $display("FAIL glitch_state got=%0d exp=%0d", dbg_state, IDLE); end
  endtask

  task automatic test_single_byte();
    do_reset();
    send_byte(8'hA5, 1'b1);
    @(negedge clk);
    tests++; if (fifo_empty !== 1'b0) begin fails++; $display("FAIL a5_empty got=%b exp=0", fifo_empty); end
    tests++; if (data_out_msd !== 4'hA) begin fails++; $display("FAIL a5_msd got=%h exp=a", data_out_msd); end
    tests++; if (data_out_lsd !== 4'h5) begin fails++; $display("FAIL a5_lsd got=%h exp=5", data_out_lsd); end
    tests++; if (error !== 1'b0) begin fails++; $display("FAIL a5_error got=%b exp=0", error); end
  endtask

  task automatic test_pop();
    do_reset();
    send_byte(8'h3C, 1'b1);
    send_byte(8'h7E, 1'b1);
    @(negedge clk);
    tests++; if ({data_out_msd, data_out_lsd} !== 8'h3C) begin fails++; $display("FAIL pop_head0 got=%h exp=3c", {data_out_msd, data_out_lsd}); end
    pulse_next(5);
    @(negedge clk);
    tests++; if ({data_out_msd, data_out_lsd} !== 8'h7E) begin fails++; $display("FAIL pop_head1 got=%h exp=7e", {data_out_msd, data_out_lsd}); end
    tests++; if (fifo_empty !== 1'b0) begin fails++; $display("FAIL pop_empty1 got=%b exp=0", fifo_empty); end
    pulse_next(5);
    @(negedge clk);
    tests++; if (fifo_empty !== 1'b1) begin fails++; $display("FAIL pop_empty2 got=%b exp=1", fifo_empty); end
    tests++; if ({data_out_msd, data_out_lsd} !== 8'h00) begin fails++; $display("FAIL pop_data2 got=%h exp=00", {data_out_msd, data_out_lsd}); end
    pulse_next(3);
    @(negedge clk);
    tests++; if (error !== 1'b0 || fifo_empty !== 1'b1) begin fails++; $display("FAIL pop_when_empty got err=%b empty=%b exp err=0 empty=1", error, fifo_empty); end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 1; i <= 4; i++) send_byte(8'(i), 1'b1);
    @(negedge clk);
    tests++; if (fifo_full !== 1'b1) begin fails++; $display("FAIL ovf_full4 got=%b exp=1", fifo_full); end
    tests++; if (error !== 1'b0) begin fails++; $display("FAIL ovf_error4 got=%b exp=0", error); end
    send_byte(8'h05, 1'b1);
    @(negedge clk);
    tests++; if (error !== 1'b1) begin fails++; $display("FAIL ovf_error5 got=%b exp=1", error); end
    tests++; if (fifo_full !== 1'b1) begin fails++; $display("FAIL ovf_full5 got=%b exp=1", fifo_full); end
    tests++; if ({data_out_msd, data_out_lsd} !== 8'h01) begin fails++; $display("FAIL ovf_head got=%h exp=01", {data_out_msd, data_out_lsd}); end
    for (int i = 0; i < 3; i++) pulse_next(2);
    @(negedge clk);
    tests++; if ({data_out_msd, data_out_lsd} !== 8'h04) begin fails++; $display("FAIL ovf_tail got=%h exp=04", {data_out_msd, data_out_lsd}); end
    pulse_next(2);
    @(negedge clk);
    tests++; if (fifo_empty !== 1'b1) begin fails++; $display("FAIL ovf_drained got=%b exp=1", fifo_empty); end
  endtask

  task automatic test_framing();
    do_reset();
    send_byte(8'h55, 1'b0);
    repeat (20) @(posedge clk);
    send_byte(8'h12, 1'b1);
    @(negedge clk);
    tests++; if (error !== 1'b1) begin fails++; $display("FAIL frm_error got=%b exp=1", error); end
    tests++; if ({data_out_msd, data_out_lsd} !== 8'h12) begin fails++; $display("FAIL frm_head got=%h exp=12", {data_out_msd, data_out_lsd}); end
    pulse_next(2);
    @(negedge clk);
    tests++; if (fifo_empty !== 1'b1) begin fails++; $display("FAIL frm_only_one got=%b exp=1", fifo_empty); end
    send_byte(8'h9B, 1'b1);
    do_reset();
    @(negedge clk);
    tests++; if (error !== 1'b0) begin fails++; $display("FAIL frm_rst_error got=%b exp=0", error); end
    tests++; if (fifo_empty !== 1'b1) begin fails++; $display("FAIL frm_rst_empty got=%b exp=1", fifo_empty); end
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_single_byte();
    test_pop();
    test_overflow();
    test_framing();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
